// File: rtl/frac_clk_div_prog.sv
// Runtime-programmable fractional clock divider: a first-order phase accumulator
// mixes N and N+1 cycle periods so the average ratio is N + F/2^FRAC_W.
module frac_clk_div_prog #(
  parameter int INT_W    = 16,
  parameter int FRAC_W   = 8,
  parameter int DEF_INT  = 4,
  parameter int DEF_FRAC = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [INT_W-1:0]  cfg_int_i,
  input  logic [FRAC_W-1:0] cfg_frac_i,
  output logic              cfg_err_o,
  output logic              clk_out_o,
  output logic              tick_o,
  output logic              running_o
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_e;

  localparam logic [INT_W:0]    ONE   = (INT_W+1)'(1);
  localparam logic [INT_W-1:0]  MIN_N = INT_W'(2);
  localparam logic [INT_W-1:0]  DEF_N = INT_W'(DEF_INT);
  localparam logic [FRAC_W-1:0] DEF_F = FRAC_W'(DEF_FRAC);

  state_e              state_q, state_d;
  logic [INT_W:0]      cnt_q, cnt_d, per_q, per_d;
  logic [FRAC_W-1:0]   acc_q, acc_d;
  logic [INT_W-1:0]    act_int_q, act_int_d, pend_int_q, pend_int_d;
  logic [FRAC_W-1:0]   act_frac_q, act_frac_d, pend_frac_q, pend_frac_d;
  logic                pend_vld_q, pend_vld_d;
  logic                rdy_q, rdy_d, err_q, err_d;
  logic                clk_q, clk_d, tick_q, tick_d, run_q, run_d;

  logic                xfer, cfg_ok, bnd, start;
  logic [INT_W-1:0]    nxt_int;
  logic [FRAC_W-1:0]   nxt_frac;
  logic [FRAC_W:0]     sum;

  assign xfer     = cfg_valid_i && rdy_q;
  assign cfg_ok   = (cfg_int_i >= MIN_N);
  assign bnd      = (state_q != IDLE) && (cnt_q == per_q - ONE);
  // A pending config is always consumed on the same edge a new period starts,
  // so the period it governs is built from it directly.
  assign nxt_int  = pend_vld_q ? pend_int_q  : act_int_q;
  assign nxt_frac = pend_vld_q ? pend_frac_q : act_frac_q;
  assign sum      = {1'b0, acc_q} + {1'b0, nxt_frac};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    per_d       = per_q;
    acc_d       = acc_q;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;
    pend_int_d  = pend_int_q;
    pend_frac_d = pend_frac_q;
    pend_vld_d  = pend_vld_q;
    rdy_d       = rdy_q;
    start       = 1'b0;
    err_d       = xfer && !cfg_ok;
    clk_d       = (state_q != IDLE) && (cnt_q < (per_q >> 1));
    tick_d      = (state_q == RUN) && (cnt_q == '0);
    run_d       = (state_q == RUN);

    case (state_q)
      IDLE: begin
        if (en_i) begin
          start   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bnd) begin
          if (en_i) start = 1'b1;
          else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          if (!en_i) state_d = STOP;
        end
      end
      STOP: begin
        if (bnd) begin
          if (en_i) begin
            start   = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          if (en_i) state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (start) begin
      cnt_d = '0;
      acc_d = sum[FRAC_W-1:0];
      per_d = {1'b0, nxt_int} + {{INT_W{1'b0}}, sum[FRAC_W]};
    end

    if (pend_vld_q && (state_q == IDLE || bnd)) begin
      act_int_d  = pend_int_q;
      act_frac_d = pend_frac_q;
      pend_vld_d = 1'b0;
      rdy_d      = 1'b1;
    end

    // rdy_q high implies nothing pending, so this never collides with the copy
    if (xfer && cfg_ok) begin
      pend_int_d  = cfg_int_i;
      pend_frac_d = cfg_frac_i;
      pend_vld_d  = 1'b1;
      rdy_d       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      per_q       <= {1'b0, DEF_N};
      acc_q       <= '0;
      act_int_q   <= DEF_N;
      act_frac_q  <= DEF_F;
      pend_int_q  <= '0;
      pend_frac_q <= '0;
      pend_vld_q  <= 1'b0;
      rdy_q       <= 1'b1;
      err_q       <= 1'b0;
      clk_q       <= 1'b0;
      tick_q      <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      per_q       <= per_d;
      acc_q       <= acc_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
      pend_int_q  <= pend_int_d;
      pend_frac_q <= pend_frac_d;
      pend_vld_q  <= pend_vld_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
      clk_q       <= clk_d;
      tick_q      <= tick_d;
      run_q       <= run_d;
    end
  end

  assign cfg_ready_o = rdy_q;
  assign cfg_err_o   = err_q;
  assign clk_out_o   = clk_q;
  assign tick_o      = tick_q;
  assign running_o   = run_q;

endmodule

// File: tb/tb_frac_clk_div_prog.sv
// Directed bench for frac_clk_div_prog: table of ratio vectors plus hand-written
// sequences for config timing, stop, illegal config and mid-period reset.
module tb_frac_clk_div_prog;
  localparam int INT_W  = 16;
  localparam int FRAC_W = 8;

  logic              clk = 1'b0;
  logic              rst, en, cfg_valid;
  logic              cfg_ready, cfg_err, clk_out, tick, running;
  logic [INT_W-1:0]  cfg_int;
  logic [FRAC_W-1:0] cfg_frac;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frac_clk_div_prog #(.INT_W(INT_W), .FRAC_W(FRAC_W), .DEF_INT(4), .DEF_FRAC(0)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
    .cfg_int_i(cfg_int), .cfg_frac_i(cfg_frac), .cfg_err_o(cfg_err),
    .clk_out_o(clk_out), .tick_o(tick), .running_o(running)
  );

  // period lengths / high counts listed first period first
  typedef struct packed {
    logic [15:0]      n;
    logic [7:0]       f;
    logic [3:0][7:0]  len;
    logic [3:0][7:0]  hi;
    logic [15:0]      win;
    logic [7:0]       ticks;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_int = '0; cfg_frac = '0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic program_idle(input int n, input int f);
    cfg_valid = 1'b1; cfg_int = INT_W'(n); cfg_frac = FRAC_W'(f);
    step();
    cfg_valid = 1'b0;
    step();
  endtask

  task automatic wait_tick(input string name);
    int k;
    k = 0;
    do begin step(); k++; end while (!tick && k < 40);
    check(name, int'(tick), 1);
  endtask

  task automatic measure(output int len, output int hi);
    len = 0; hi = 0;
    do begin hi += int'(clk_out); len++; step(); end while (!tick && len < 64);
  endtask

  initial begin
    int l, h, cnt, pat;
    vecs[0] = '{16'd4,  8'd0,   {8'd4, 8'd4, 8'd4, 8'd4},   {8'd2, 8'd2, 8'd2, 8'd2}, 16'd0,   8'd0};
    vecs[1] = '{16'd3,  8'd0,   {8'd3, 8'd3, 8'd3, 8'd3},   {8'd1, 8'd1, 8'd1, 8'd1}, 16'd30,  8'd10};
    vecs[2] = '{16'd2,  8'd128, {8'd2, 8'd3, 8'd2, 8'd3},   {8'd1, 8'd1, 8'd1, 8'd1}, 16'd10,  8'd4};
    vecs[3] = '{16'd10, 8'd64,  {8'd10, 8'd10, 8'd10, 8'd11}, {8'd5, 8'd5, 8'd5, 8'd5}, 16'd410, 8'd40};
    vecs[4] = '{16'd5,  8'd255, {8'd5, 8'd6, 8'd6, 8'd6},   {8'd2, 8'd3, 8'd3, 8'd3}, 16'd0,   8'd0};
    vecs[5] = '{16'd7,  8'd1,   {8'd7, 8'd7, 8'd7, 8'd7},   {8'd3, 8'd3, 8'd3, 8'd3}, 16'd0,   8'd0};

    // reset state and start-up latency with the default config
    do_reset();
    check("reset_state", int'({clk_out, tick, running, cfg_err, cfg_ready}), 5'b00001);
    en = 1'b1;
    step();
    check("lat_early", int'({running, clk_out, tick}), 0);
    step();
    check("lat_on", int'({running, clk_out, tick}), 3'b111);
    measure(l, h); check("def_len", l, 4); check("def_hi", h, 2);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      program_idle(int'(vecs[v].n), int'(vecs[v].f));
      en = 1'b1;
      wait_tick($sformatf("v%0d_start", v));
      for (int p = 0; p < 4; p++) begin
        measure(l, h);
        check($sformatf("v%0d_len%0d", v, p), l, int'(vecs[v].len[3-p]));
        check($sformatf("v%0d_hi%0d", v, p), h, int'(vecs[v].hi[3-p]));
      end
      if (vecs[v].win != 0) begin
        cnt = 0;
        for (int c = 0; c < int'(vecs[v].win); c++) begin cnt += int'(tick); step(); end
        check($sformatf("v%0d_ticks", v), cnt, int'(vecs[v].ticks));
      end
    end

    // config update mid-period: 4 -> 6
    do_reset(); en = 1'b1;
    wait_tick("upd_start");
    step();
    cfg_valid = 1'b1; cfg_int = 16'd6; cfg_frac = 8'd0;
    step();
    cfg_valid = 1'b0;
    check("upd_rdy_lo", int'(cfg_ready), 0);
    step();
    check("upd_rdy_hi", int'(cfg_ready), 1);
    step();
    check("upd_old_len", int'(tick), 1);
    measure(l, h); check("upd_new_len", l, 6); check("upd_new_hi", h, 3);

    // transfer on the boundary cycle applies one period later
    do_reset(); en = 1'b1;
    wait_tick("bnd_start");
    step(); step();
    cfg_valid = 1'b1; cfg_int = 16'd3; cfg_frac = 8'd0;
    step();
    cfg_valid = 1'b0;
    check("bnd_rdy_lo", int'(cfg_ready), 0);
    step();
    check("bnd_tick", int'(tick), 1);
    measure(l, h); check("bnd_len_a", l, 4); check("bnd_hi_a", h, 2);
    measure(l, h); check("bnd_len_b", l, 3); check("bnd_hi_b", h, 1);

    // en dropped early in an N=8 period: period completes, then idle
    do_reset(); program_idle(8, 0); en = 1'b1;
    wait_tick("stop_start");
    en = 1'b0;
    pat = 0;
    for (int c = 0; c < 8; c++) begin pat = (pat << 1) | int'(clk_out); step(); end
    check("stop_shape", pat, 8'b11110000);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin cnt += int'(tick) + int'(clk_out); step(); end
    check("stop_idle", cnt, 0);
    check("stop_running", int'(running), 0);

    // illegal config: error pulse, ratio unchanged
    do_reset(); en = 1'b1;
    wait_tick("err_start");
    cfg_valid = 1'b1; cfg_int = 16'd1; cfg_frac = 8'd0;
    step();
    cfg_valid = 1'b0;
    check("err_pulse", int'({cfg_err, cfg_ready}), 2'b11);
    step();
    check("err_clear", int'(cfg_err), 0);
    wait_tick("err_tick");
    measure(l, h); check("err_len", l, 4); check("err_hi", h, 2);

    // reset in the middle of a running period
    do_reset(); program_idle(8, 0); en = 1'b1;
    wait_tick("rst_start");
    step();
    check("rst_pre", int'(clk_out), 1);
    rst = 1'b1;
    step();
    check("rst_mid", int'({clk_out, tick, running, cfg_err, cfg_ready}), 5'b00001);
    rst = 1'b0; en = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
